// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator driving a byte-addressable data RAM.
// Define MEM_ACCESS_SPLIT_EN to split misaligned half/word accesses into unsigned-byte accesses.
module mem_access_unit #(
   parameter int MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_u_b_h_w,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   output logic [2:0]  mem_u_b_h_w,
   input  logic [31:0] mem_dout
);
   localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, RESP = 2'd3;
   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
   logic [2:0]  ubhw_q, ubhw_d;
   logic        we_q, we_d, err_q, err_d;
   logic [2:0]  size;
   logic        mis, oor, bad;
   assign size = req_u_b_h_w[1] ? 3'd4 : req_u_b_h_w[0] ? 3'd2 : 3'd1;
   assign mis  = req_u_b_h_w[1] ? |req_addr[1:0] : req_u_b_h_w[0] & req_addr[0];
   // 33-bit sum so an access wrapping past 2^32 is caught as out of range
   assign oor  = {1'b0, req_addr} + 33'(size) - 33'd1 >= 33'(MEM_BYTES);
`ifdef MEM_ACCESS_SPLIT_EN
   localparam logic [1:0] SPLIT = 2'd2;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] base_q, base_d, wdata_q, wdata_d, asm_q, asm_d;
   logic [2:0]  osz_q, osz_d;
   assign bad = oor;
`else
   assign bad = oor | mis;
`endif
   assign req_ready   = state_q == IDLE;
   assign resp_valid  = state_q == RESP;
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;
   assign mem_addr    = addr_q;
   assign mem_din     = din_q;
   assign mem_we      = we_q;
   assign mem_u_b_h_w = ubhw_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      din_d   = din_q;
      ubhw_d  = ubhw_q;
      we_d    = 1'b0;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef MEM_ACCESS_SPLIT_EN
      cnt_d   = cnt_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      osz_d   = osz_q;
      asm_d   = asm_q;
`endif
      case (state_q)
         IDLE: if (req_valid) begin
            if (bad) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end
`ifdef MEM_ACCESS_SPLIT_EN
            else if (mis) begin
               state_d = SPLIT;
               addr_d  = req_addr;
               din_d   = {24'd0, req_wdata[7:0]};
               ubhw_d  = 3'b100;
               we_d    = req_we;
               cnt_d   = 2'd0;
               base_d  = req_addr;
               wdata_d = req_wdata;
               osz_d   = req_u_b_h_w;
            end
`endif
            else begin
               state_d = ACC;
               addr_d  = req_addr;
               din_d   = req_wdata;
               ubhw_d  = req_u_b_h_w;
               we_d    = req_we;
            end
         end
         ACC: begin
            state_d = RESP;
            rdata_d = we_q ? '0 : mem_dout;
            err_d   = 1'b0;
         end
`ifdef MEM_ACCESS_SPLIT_EN
         SPLIT: begin
            asm_d[{cnt_q, 3'b000} +: 8] = mem_dout[7:0];
            // last byte index is 3 for a word, 1 for a half
            if (cnt_q == {osz_q[1], 1'b1}) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : osz_q[1] ? asm_d :
                         osz_q[2] ? {16'd0, asm_d[15:0]} : {{16{asm_d[15]}}, asm_d[15:0]};
            end else begin
               cnt_d  = cnt_q + 2'd1;
               addr_d = base_q + 32'(cnt_d);
               din_d  = {24'd0, wdata_q[{cnt_d, 3'b000} +: 8]};
               we_d   = we_q;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         din_q   <= '0;
         ubhw_q  <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         ubhw_q  <= ubhw_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
`ifdef MEM_ACCESS_SPLIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         base_q  <= '0;
         wdata_q <= '0;
         osz_q   <= '0;
         asm_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         osz_q   <= osz_d;
         asm_q   <= asm_d;
      end
   end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random + directed bench for mem_access_unit against a RAM model
// and a byte-level reference model of load/store results, errors, latency and write count.
module tb_mem_access_unit;
   localparam int MB = 128;
`ifdef MEM_ACCESS_SPLIT_EN
   localparam bit SPLIT_ON = 1'b1;
`else
   localparam bit SPLIT_ON = 1'b0;
`endif
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nw;
      int          acc;
   } exp_t;

   logic        clk = 1'b0, rst_n;
   logic        req_valid, req_ready, req_we, resp_valid, resp_err, mem_we;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_din, mem_dout, raw;
   logic [2:0]  req_u_b_h_w, mem_u_b_h_w;

   byte unsigned ram [MB];
   byte unsigned shadow [MB];
   exp_t        q [$];
   exp_t        e;
   logic [63:0] wlog [$];
   int checks = 0, fails = 0, cyc = 0, we_cnt = 0, resp_cnt = 0, last_lat = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   int          wsz;

   mem_access_unit #(.MEM_BYTES(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_u_b_h_w(req_u_b_h_w),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_u_b_h_w(mem_u_b_h_w), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: combinational extended read, byte-lane write on negedge
   always_comb begin
      raw = '0;
      for (int i = 0; i < 4; i++)
         if ({1'b0, mem_addr} + 33'(i) < 33'(MB)) raw[8*i +: 8] = ram[int'(mem_addr) + i];
   end
   assign mem_dout = mem_u_b_h_w[1] ? raw :
                     mem_u_b_h_w[0] ? (mem_u_b_h_w[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]}) :
                                      (mem_u_b_h_w[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]});
   assign wsz = mem_u_b_h_w[1] ? 4 : mem_u_b_h_w[0] ? 2 : 1;
   always @(negedge clk)
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (i < wsz && {1'b0, mem_addr} + 33'(i) < 33'(MB)) ram[int'(mem_addr) + i] <= mem_din[8*i +: 8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Reference: what one request must produce, applied to the shadow memory
   function automatic void model(input logic we, input logic [31:0] a, input logic [2:0] u,
                                 input logic [31:0] wd, output exp_t r);
      int sz = u[1] ? 4 : u[0] ? 2 : 1;
      longint unsigned ea = a;
      bit mis = (ea % sz) != 0;
      bit err = (ea + sz - 1 >= MB) || (mis && !SPLIT_ON);
      logic [31:0] v = '0;
      r.err = err;
      r.lat = err ? 1 : mis ? 1 + sz : 2;
      r.nw  = (we && !err) ? (mis ? sz : 1) : 0;
      r.acc = 0;
      if (!err)
         for (int i = 0; i < sz; i++)
            if (we) shadow[int'(a) + i] = wd[8*i +: 8];
            else v[8*i +: 8] = shadow[int'(a) + i];
      if (we || err) r.rdata = '0;
      else if (sz == 4) r.rdata = v;
      else if (sz == 2) r.rdata = u[2] ? v : {{16{v[15]}}, v[15:0]};
      else r.rdata = u[2] ? v : {{24{v[7]}}, v[7:0]};
   endfunction

   initial forever begin
      @(negedge clk);
      if (!rst_n) we_cnt = 0;
      else begin
         chk("ready_and_valid", 32'(resp_valid & req_ready), 32'd0);
         if (mem_we) begin
            we_cnt++;
            wlog.push_back({mem_addr, mem_din});
         end
         if (resp_valid) begin
            resp_cnt++;
            last_rdata = resp_rdata;
            last_err = resp_err;
            if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               last_lat = cyc - e.acc + 1;
               chk("resp_err", 32'(resp_err), 32'(e.err));
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("latency", 32'(last_lat), 32'(e.lat));
               chk("write_cycles", 32'(we_cnt), 32'(e.nw));
            end
            we_cnt = 0;
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] u,
                        input logic [31:0] wd, output int acc);
      exp_t r;
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_u_b_h_w = u; req_wdata = wd;
      acc = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk); #1;
         acc = cyc;
         model(we, a, u, wd, r);
         r.acc = acc;
         q.push_back(r);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("resp_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] u, input logic [31:0] wd);
      int acc;
      issue(we, a, u, wd, acc);
      req_valid = 1'b0;
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1, a2, a3, diff, r;
      logic [31:0] ra;
      logic [63:0] w;
      logic [7:0] exp_b [4];
      exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_u_b_h_w = 0; rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_din", mem_din, 32'd0);
      chk("rst_mem_ubhw", 32'(mem_u_b_h_w), 32'd0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      // aligned word store/load
      wlog.delete();
      xact(1, 32'h10, 3'b010, 32'hDEADBEEF);
      chk("st_we_cycles", 32'(wlog.size()), 32'd1);
      w = wlog.size() > 0 ? wlog[0] : 64'd0;
      chk("st_mem_addr", w[63:32], 32'h10);
      chk("st_mem_din", w[31:0], 32'hDEADBEEF);
      chk("st_latency", 32'(last_lat), 32'd2);
      xact(0, 32'h10, 3'b010, 32'h0);
      chk("ld_word", last_rdata, 32'hDEADBEEF);
      chk("ld_word_err", 32'(last_err), 32'd0);
      chk("ld_word_lat", 32'(last_lat), 32'd2);
      // byte/half extension
      xact(1, 32'h20, 3'b000, 32'h80);
      xact(1, 32'h21, 3'b000, 32'hFF);
      xact(0, 32'h20, 3'b000, 0);
      chk("ld_byte_s", last_rdata, 32'hFFFFFF80);
      xact(0, 32'h20, 3'b100, 0);
      chk("ld_byte_u", last_rdata, 32'h00000080);
      xact(0, 32'h20, 3'b001, 0);
      chk("ld_half_s", last_rdata, 32'hFFFFFF80);
      xact(0, 32'h20, 3'b101, 0);
      chk("ld_half_u", last_rdata, 32'h0000FF80);
      // out of range
      xact(0, 32'h7E, 3'b010, 0);
      chk("oor_err", 32'(last_err), 32'd1);
      chk("oor_rdata", last_rdata, 32'd0);
      chk("oor_lat", 32'(last_lat), 32'd1);
      wlog.delete();
      xact(1, 32'h80, 3'b000, 32'h5A);
      chk("oor_st_err", 32'(last_err), 32'd1);
      chk("oor_st_no_we", 32'(wlog.size()), 32'd0);
      // misaligned word store
      wlog.delete();
      xact(1, 32'h11, 3'b010, 32'h11223344);
`ifdef MEM_ACCESS_SPLIT_EN
      chk("split_we_cycles", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         w = wlog.size() > i ? wlog[i] : 64'd0;
         chk("split_addr", w[63:32], 32'h11 + 32'(i));
         chk("split_byte", 32'(w[7:0]), 32'(exp_b[i]));
      end
      xact(0, 32'h11, 3'b010, 0);
      chk("split_ld", last_rdata, 32'h11223344);
      chk("split_lat", 32'(last_lat), 32'd5);
`else
      chk("mis_err", 32'(last_err), 32'd1);
      chk("mis_no_we", 32'(wlog.size()), 32'd0);
      chk("mis_ram", {ram[20], ram[19], ram[18], ram[17]}, 32'h00DEADBE);
      chk("mis_exp_b", 32'(exp_b[0]), 32'h44);
`endif
      // reset during ACC of a store
      req_valid = 1; req_we = 1; req_addr = 32'h40; req_u_b_h_w = 3'b010; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 0;
      chk("acc_mem_we", 32'(mem_we), 32'd1);
      rst_n = 0;
      #1;
      chk("async_mem_we", 32'(mem_we), 32'd0);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      xact(0, 32'h40, 3'b010, 0);
      chk("aborted_store", last_rdata, 32'd0);
      // back-to-back with req_valid held
      issue(0, 32'h10, 3'b010, 0, a1);
      issue(0, 32'h20, 3'b000, 0, a2);
      issue(0, 32'h20, 3'b101, 0, a3);
      req_valid = 0;
      wait_idle();
      chk("b2b_gap1", 32'(a2 - a1), 32'd3);
      chk("b2b_gap2", 32'(a3 - a2), 32'd3);
      // random traffic
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         ra = r == 0 ? 32'hFFFFFFFC + $urandom_range(0, 3) :
              r == 1 ? 32'(MB - 4) + $urandom_range(0, 7) : $urandom_range(0, MB - 1);
         xact(1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      diff = 0;
      for (int i = 0; i < MB; i++) if (ram[i] != shadow[i]) diff++;
      chk("ram_vs_model", 32'(diff), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
